// File: rtl/pat_mem_pkg.sv
// -----------------------------------------------------------------------------
// pat_mem_pkg
// Shared constants and types for the pattern-memory arbiter slice.
//   PAT_MEM_ADDR_W : word address width of the pattern memory
//   PAT_MEM_DATA_W : word width of the pattern memory
//   PAT_MEM_BE_W   : byte-enable width (one bit per data byte)
//   PAT_MEM_RD_LAT : memory read latency in cycles, counted from the issue cycle
//   grant_t        : identifies which requester won the last arbitration
// -----------------------------------------------------------------------------
package pat_mem_pkg;

    localparam int PAT_MEM_ADDR_W = 11;
    localparam int PAT_MEM_DATA_W = 256;
    localparam int PAT_MEM_BE_W   = PAT_MEM_DATA_W / 8;
    localparam int PAT_MEM_RD_LAT = 1;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_t;

endpackage

// File: rtl/pat_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// pat_mem_arbiter_if
// Bundles the fetch read port, the loader write port and the memory command
// bus of the pattern-memory arbiter.
//   slave  : arbiter view (takes requests, drives grants and memory commands)
//   master : environment view (requesters plus the memory itself)
// Read port : rd_req, rd_addr -> rd_gnt, rd_data, rd_valid
// Write port: wr_req, wr_addr, wr_data, wr_be -> wr_gnt, wr_starved
// Memory    : mem_chip_select, mem_read, mem_write, mem_addr, mem_byte_enable,
//             mem_write_data -> memory; mem_read_data <- memory
// -----------------------------------------------------------------------------
interface pat_mem_arbiter_if #(
    parameter int ADDR_W = pat_mem_pkg::PAT_MEM_ADDR_W,
    parameter int DATA_W = pat_mem_pkg::PAT_MEM_DATA_W
);
    import pat_mem_pkg::*;

    localparam int BE_W = DATA_W / 8;

    // fetch read port
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    // loader write port
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
    logic              wr_gnt;
    logic              wr_starved;

    // memory command bus
    logic              mem_chip_select;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_byte_enable;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  rd_req, rd_addr,
        output rd_gnt, rd_data, rd_valid,
        input  wr_req, wr_addr, wr_data, wr_be,
        output wr_gnt, wr_starved,
        output mem_chip_select, mem_read, mem_write, mem_addr,
        output mem_byte_enable, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output rd_req, rd_addr,
        input  rd_gnt, rd_data, rd_valid,
        output wr_req, wr_addr, wr_data, wr_be,
        input  wr_gnt, wr_starved,
        input  mem_chip_select, mem_read, mem_write, mem_addr,
        input  mem_byte_enable, mem_write_data,
        output mem_read_data
    );

endinterface

// File: rtl/pat_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pat_mem_arbiter
// Shares the single-port pattern memory between the pixel fetch engine (reads)
// and the host pattern loader (writes).
//   clk          : single clock
//   rst_n        : asynchronous active-low reset
//   frame_active : 1 = read-priority mode with bounded write starvation,
//                  0 = round-robin between the two ports
//   bus          : pat_mem_arbiter_if.slave (read port, write port, memory bus)
// Timing: grant is combinational in cycle t, the command is on mem_* in t+1,
// rd_data/rd_valid appear in t+2. One grant at most per cycle.
// -----------------------------------------------------------------------------
module pat_mem_arbiter
    import pat_mem_pkg::*;
#(
    parameter int ADDR_W        = PAT_MEM_ADDR_W,
    parameter int DATA_W        = PAT_MEM_DATA_W,
    parameter int MAX_WR_STARVE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_active,
    pat_mem_arbiter_if.slave bus
);

    localparam int BE_W         = DATA_W / 8;
    localparam int STARVE_W     = $clog2(MAX_WR_STARVE + 1);
    localparam int VALID_STAGES = PAT_MEM_RD_LAT + 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_WR_STARVE);

    // arbitration
    logic                    rd_win;
    logic                    wr_win;
    logic                    forced_win;
    logic                    starve_sat;
    logic [STARVE_W-1:0]     starve_cnt_reg;
    logic [STARVE_W-1:0]     starve_cnt_next;
    grant_t                  last_grant_reg;
    grant_t                  last_grant_next;

    // issue register
    logic                    mem_cs_reg;
    logic                    mem_read_reg;
    logic                    mem_write_reg;
    logic [ADDR_W-1:0]       mem_addr_reg;
    logic [BE_W-1:0]         mem_be_reg;
    logic [DATA_W-1:0]       mem_wdata_reg;

    // read return
    logic [VALID_STAGES-1:0] rd_vpipe_reg;
    logic [DATA_W-1:0]       rd_data_reg;

    assign starve_sat = (starve_cnt_reg == STARVE_MAX);

    // Grant decision plus next-state of the starve counter and last-grant flag.
    // Grants are suppressed while reset is asserted so nothing is accepted
    // that the issue register would then drop.
    always_comb begin
        rd_win          = 1'b0;
        wr_win          = 1'b0;
        forced_win      = 1'b0;
        starve_cnt_next = starve_cnt_reg;
        last_grant_next = last_grant_reg;

        if (rst_n) begin
            if (frame_active) begin
                // Reads own the memory during the frame, except for one
                // write let through once the loader has waited long enough.
                if (bus.rd_req && bus.wr_req && starve_sat) begin
                    wr_win     = 1'b1;
                    forced_win = 1'b1;
                end else if (bus.rd_req) begin
                    rd_win = 1'b1;
                end else if (bus.wr_req) begin
                    wr_win = 1'b1;
                end
            end else begin
                // Round-robin on contention: the port not served last wins.
                if (bus.rd_req && bus.wr_req) begin
                    if (last_grant_reg == GNT_WR) begin
                        rd_win = 1'b1;
                    end else begin
                        wr_win = 1'b1;
                    end
                end else if (bus.rd_req) begin
                    rd_win = 1'b1;
                end else if (bus.wr_req) begin
                    wr_win = 1'b1;
                end
            end
        end

        if (!frame_active || wr_win) begin
            starve_cnt_next = '0;
        end else if (bus.wr_req && !starve_sat) begin
            starve_cnt_next = starve_cnt_reg + STARVE_W'(1);
        end

        if (rd_win) begin
            last_grant_next = GNT_RD;
        end else if (wr_win) begin
            last_grant_next = GNT_WR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_reg <= '0;
            last_grant_reg <= GNT_WR;
            mem_cs_reg     <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_be_reg     <= '0;
            mem_wdata_reg  <= '0;
            rd_vpipe_reg   <= '0;
            rd_data_reg    <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            last_grant_reg <= last_grant_next;

            mem_cs_reg     <= rd_win | wr_win;
            mem_read_reg   <= rd_win;
            mem_write_reg  <= wr_win;
            mem_addr_reg   <= rd_win ? bus.rd_addr : (wr_win ? bus.wr_addr : '0);
            // Reads present every byte lane; idle cycles keep the write side at 0.
            mem_be_reg     <= wr_win ? bus.wr_be : (rd_win ? {BE_W{1'b1}} : '0);
            mem_wdata_reg  <= wr_win ? bus.wr_data : '0;

            // Stage 0 follows the issue cycle, the last stage is rd_valid.
            rd_vpipe_reg   <= {rd_vpipe_reg[VALID_STAGES-2:0], rd_win};
            if (rd_vpipe_reg[VALID_STAGES-2]) begin
                rd_data_reg <= bus.mem_read_data;
            end
        end
    end

    assign bus.rd_gnt          = rd_win;
    assign bus.wr_gnt          = wr_win;
    assign bus.wr_starved      = forced_win;
    assign bus.rd_valid        = rd_vpipe_reg[VALID_STAGES-1];
    assign bus.rd_data         = rd_data_reg;
    assign bus.mem_chip_select = mem_cs_reg;
    assign bus.mem_read        = mem_read_reg;
    assign bus.mem_write       = mem_write_reg;
    assign bus.mem_addr        = mem_addr_reg;
    assign bus.mem_byte_enable = mem_be_reg;
    assign bus.mem_write_data  = mem_wdata_reg;

endmodule

// File: tb/tb_pat_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pat_mem_arbiter
// Bench for pat_mem_arbiter: a memory model on the mem_* bus, a shadow copy of
// the memory updated in grant order, a queue of expected read returns, a table
// of arbitration vectors and hand-written sequences for the multi-cycle cases.
// -----------------------------------------------------------------------------
module tb_pat_mem_arbiter;
    import pat_mem_pkg::*;

    localparam int AW    = PAT_MEM_ADDR_W;
    localparam int DW    = PAT_MEM_DATA_W;
    localparam int BW    = PAT_MEM_BE_W;
    localparam int DEPTH = 2048;
    localparam int MAXS  = 8;
    localparam int NVEC  = 25;

    logic clk;
    logic rst_n;
    logic frame_active;

    pat_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    pat_mem_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_WR_STARVE(MAXS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_active(frame_active),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] init_word(input int i);
        logic [DW-1:0] w;
        w = {8{32'hC0DE_0000 | 32'(i)}};
        if (i == 5) w = {32{8'hAA}};
        return w;
    endfunction

    // Memory model: the word at mem_addr is presented while mem_read is high
    // and captured by the arbiter at the end of that cycle; writes land on
    // the clock edge that ends the mem_write cycle.
    logic [DW-1:0] mem_array [DEPTH];
    assign bus.mem_read_data = bus.mem_read ? mem_array[bus.mem_addr] : '0;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_array[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (bus.mem_write) begin
                for (int b = 0; b < BW; b++) begin
                    if (bus.mem_byte_enable[b])
                        mem_array[bus.mem_addr][b*8 +: 8] = bus.mem_write_data[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- scoreboard and checking ----------------
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } sb_t;

    typedef struct {
        logic fa, rd, wr, e_rd, e_wr, e_st;
    } vec_t;

    sb_t           sb_q[$];
    logic [DW-1:0] model [DEPTH];
    vec_t          vecs [NVEC];
    int            checks;
    int            errors;
    int            cyc;

    logic          s_rd_gnt, s_wr_gnt, s_starved, s_rd_valid;
    logic          s_mem_cs, s_mem_read, s_mem_write;
    logic [AW-1:0] s_mem_addr;
    logic [BW-1:0] s_mem_be;
    logic [DW-1:0] s_mem_wdata, s_rd_data;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Samples the DUT on the falling edge, retires due reads and records new
    // grants: a granted write updates the shadow memory at once, so a read
    // granted afterwards expects the new data and an earlier one the old.
    task automatic sb_step();
        sb_t e;
        @(negedge clk);
        cyc++;
        s_rd_gnt    = bus.rd_gnt;
        s_wr_gnt    = bus.wr_gnt;
        s_starved   = bus.wr_starved;
        s_rd_valid  = bus.rd_valid;
        s_rd_data   = bus.rd_data;
        s_mem_cs    = bus.mem_chip_select;
        s_mem_read  = bus.mem_read;
        s_mem_write = bus.mem_write;
        s_mem_addr  = bus.mem_addr;
        s_mem_be    = bus.mem_byte_enable;
        s_mem_wdata = bus.mem_write_data;
        if (!rst_n) begin
            sb_q.delete();
            return;
        end
        chk("one_grant", DW'(s_rd_gnt & s_wr_gnt), '0);
        if (s_rd_valid) begin
            if (sb_q.size() == 0) begin
                chk("rd_valid_unexpected", DW'(s_rd_valid), '0);
            end else begin
                e = sb_q.pop_front();
                chk("rd_data_sb", s_rd_data, e.data);
                chk("rd_valid_latency", DW'(cyc), DW'(e.due));
            end
        end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            void'(sb_q.pop_front());
            chk("rd_valid_missing", DW'(s_rd_valid), DW'(1));
        end
        if (s_rd_gnt) begin
            e.data = model[bus.rd_addr];
            e.due  = cyc + 2;
            sb_q.push_back(e);
        end
        if (s_wr_gnt) begin
            for (int b = 0; b < BW; b++) begin
                if (bus.wr_be[b]) model[bus.wr_addr][b*8 +: 8] = bus.wr_data[b*8 +: 8];
            end
        end
    endtask

    // Drives one cycle of stimulus (called just after a rising edge), samples
    // it, and returns just after the next rising edge.
    task automatic run_cycle(input logic fa, input logic rd, input logic [AW-1:0] ra,
                             input logic wr, input logic [AW-1:0] wa,
                             input logic [DW-1:0] wd, input logic [BW-1:0] be);
        frame_active = fa;
        bus.rd_req   = rd;
        bus.rd_addr  = ra;
        bus.wr_req   = wr;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.wr_be    = be;
        sb_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic fa);
        run_cycle(fa, 1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic reset_dut();
        rst_n        = 1'b0;
        frame_active = 1'b0;
        bus.rd_req   = 1'b0;
        bus.wr_req   = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic fa, rd, wr, e_rd, e_wr, e_st);
        vec_t v;
        v.fa = fa; v.rd = rd; v.wr = wr; v.e_rd = e_rd; v.e_wr = e_wr; v.e_st = e_st;
        return v;
    endfunction

    initial begin
        logic [DW-1:0] exp_w;
        logic [DW-1:0] aa_w;
        int            nv, first_v, last_v, k;

        checks = 0;
        errors = 0;
        cyc    = 0;
        for (int i = 0; i < DEPTH; i++) model[i] = init_word(i);
        aa_w = {32{8'hAA}};

        // Round-robin (after reset), then read priority and forced write.
        for (int i = 0; i < 6; i++) vecs[i] = mk(0, 1, 1, (i % 2) == 0, (i % 2) == 1, 0);
        vecs[6] = mk(0, 0, 1, 0, 1, 0);
        vecs[7] = mk(0, 1, 0, 1, 0, 0);
        vecs[8] = mk(0, 1, 1, 0, 1, 0);
        vecs[9] = mk(0, 0, 0, 0, 0, 0);
        for (int i = 10; i < 18; i++) vecs[i] = mk(1, 1, 1, 1, 0, 0);
        vecs[18] = mk(1, 1, 1, 0, 1, 1);
        vecs[19] = mk(1, 1, 1, 1, 0, 0);
        vecs[20] = mk(1, 1, 1, 1, 0, 0);
        vecs[21] = mk(0, 1, 1, 0, 1, 0);
        vecs[22] = mk(1, 1, 1, 1, 0, 0);
        vecs[23] = mk(1, 0, 1, 0, 1, 0);
        vecs[24] = mk(1, 1, 0, 1, 0, 0);

        // ---- reset state ----
        rst_n        = 1'b0;
        frame_active = 1'b0;
        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
        bus.wr_req   = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_be    = '0;
        @(posedge clk);
        #1;
        chk("rst_mem_cs", DW'(bus.mem_chip_select), '0);
        chk("rst_mem_read", DW'(bus.mem_read), '0);
        chk("rst_mem_write", DW'(bus.mem_write), '0);
        chk("rst_mem_addr", DW'(bus.mem_addr), '0);
        chk("rst_mem_be", DW'(bus.mem_byte_enable), '0);
        chk("rst_mem_wdata", bus.mem_write_data, '0);
        chk("rst_rd_valid", DW'(bus.rd_valid), '0);
        chk("rst_rd_data", bus.rd_data, '0);
        chk("rst_wr_starved", DW'(bus.wr_starved), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---- single read at 0x005 ----
        run_cycle(0, 1, 11'h005, 0, '0, '0, '0);
        chk("t0_rd_gnt", DW'(s_rd_gnt), DW'(1));
        idle(0);
        chk("t1_mem_read", DW'(s_mem_read), DW'(1));
        chk("t1_mem_cs", DW'(s_mem_cs), DW'(1));
        chk("t1_mem_addr", DW'(s_mem_addr), DW'(11'h005));
        chk("t1_mem_be", DW'(s_mem_be), DW'({BW{1'b1}}));
        chk("t1_mem_wdata", s_mem_wdata, '0);
        chk("t1_no_valid", DW'(s_rd_valid), '0);
        idle(0);
        chk("t2_rd_valid", DW'(s_rd_valid), DW'(1));
        chk("t2_rd_data", s_rd_data, aa_w);

        // ---- write then read same address: new data, lanes 0-3 only ----
        run_cycle(0, 0, '0, 1, 11'h010, DW'(32'h1234), 32'h0000_000F);
        chk("wr_gnt_hazard", DW'(s_wr_gnt), DW'(1));
        run_cycle(0, 1, 11'h010, 0, '0, '0, '0);
        chk("rd_gnt_hazard", DW'(s_rd_gnt), DW'(1));
        chk("wr_issue_write", DW'(s_mem_write), DW'(1));
        chk("wr_issue_be", DW'(s_mem_be), DW'(32'h0000_000F));
        chk("wr_issue_data", s_mem_wdata, DW'(32'h1234));
        // read then write same address: old data
        run_cycle(0, 1, 11'h011, 0, '0, '0, '0);
        run_cycle(0, 0, '0, 1, 11'h011, {DW{1'b1}}, {BW{1'b1}});
        chk("raw_rd_valid", DW'(s_rd_valid), DW'(1));
        exp_w = init_word(16);
        exp_w[31:0] = 32'h0000_1234;
        chk("raw_new_data", s_rd_data, exp_w);
        idle(0);
        chk("war_rd_valid", DW'(s_rd_valid), DW'(1));
        chk("war_old_data", s_rd_data, init_word(17));
        idle(0);

        // ---- arbitration table ----
        reset_dut();
        for (int i = 0; i < NVEC; i++) begin
            run_cycle(vecs[i].fa, vecs[i].rd, AW'(32'h20 + i), vecs[i].wr, AW'(32'h100 + i),
                      {8{$urandom()}}, $urandom());
            chk($sformatf("vec%0d_rd_gnt", i), DW'(s_rd_gnt), DW'(vecs[i].e_rd));
            chk($sformatf("vec%0d_wr_gnt", i), DW'(s_wr_gnt), DW'(vecs[i].e_wr));
            chk($sformatf("vec%0d_starved", i), DW'(s_starved), DW'(vecs[i].e_st));
        end
        idle(1);
        idle(1);

        // ---- 16 back-to-back reads during the frame ----
        nv = 0; first_v = -1; last_v = -1; k = 0;
        for (int i = 0; i < 16; i++) begin
            run_cycle(1, 1, AW'(i), 0, '0, '0, '0);
            if (s_rd_valid) begin
                nv++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
            k++;
        end
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (s_rd_valid) begin
                nv++;
                if (first_v < 0) first_v = k;
                last_v = k;
            end
            k++;
        end
        chk("b2b_count", DW'(nv), DW'(16));
        chk("b2b_first", DW'(first_v), DW'(2));
        chk("b2b_no_gap", DW'(last_v - first_v), DW'(15));

        // ---- asynchronous reset with two reads in flight ----
        run_cycle(1, 1, 11'h040, 0, '0, '0, '0);
        frame_active = 1'b1;
        bus.rd_req   = 1'b1;
        bus.rd_addr  = 11'h041;
        sb_step();
        chk("inflight_rd_gnt", DW'(s_rd_gnt), DW'(1));
        chk("inflight_mem_read", DW'(s_mem_read), DW'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mem_cs", DW'(bus.mem_chip_select), '0);
        chk("arst_mem_read", DW'(bus.mem_read), '0);
        chk("arst_mem_addr", DW'(bus.mem_addr), '0);
        chk("arst_mem_be", DW'(bus.mem_byte_enable), '0);
        chk("arst_rd_valid", DW'(bus.rd_valid), '0);
        chk("arst_rd_gnt", DW'(bus.rd_gnt), '0);
        sb_q.delete();
        bus.rd_req = 1'b0;
        @(posedge clk);
        #1;
        idle(1);
        chk("arst_hold_valid", DW'(s_rd_valid), '0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) idle(1);
        run_cycle(1, 1, 11'h042, 0, '0, '0, '0);
        chk("post_rst_rd_gnt", DW'(s_rd_gnt), DW'(1));
        for (int i = 0; i < 3; i++) idle(1);

        chk("sb_drain", DW'(sb_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
